// File: rtl/vga_arb_pkg.sv
// Shared types and constants for the VGA pixel-SRAM write arbiter.
package vga_arb_pkg;

  localparam int unsigned COLOR_W       = 8;
  localparam int unsigned DEFAULT_N_REQ = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } arb_state_t;

endpackage

// File: rtl/vga_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index after rr_last, modulo N_REQ.
module rr_picker #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] rr_last,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] cand;

  // Scan farthest-first so the nearest eligible index after rr_last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      cand = IDX_W'((32'(rr_last) + k) % N_REQ);
      if (eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the VGA pixel-SRAM write port with frame-window filtering.
// Optional per-requester accepted-write counters are built when ARB_STATS_EN is defined.
module vga_write_arbiter
  import vga_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = DEFAULT_N_REQ,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = COLOR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [ADDR_W-1:0]       base,
  input  logic [ADDR_W-1:0]       limit,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_done,
  output logic [N_REQ-1:0]        ack,
  output logic [ADDR_W-1:0]       vga_sram_address,
  output logic [DATA_W-1:0]       vga_sram_writedata,
  output logic                    vga_sram_write,
  output logic                    vga_sram_clken,
  output logic                    vga_sram_chipselect,
  output logic                    range_err,
  output logic                    all_done,
  output logic [N_REQ*32-1:0]     write_count
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] rr_last, grant_idx;
  logic             grant_valid, grant, in_range;
  logic [N_REQ-1:0] eligible;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // The pulsing ack masks its own request; finished requesters are ignored.
  assign eligible = req & ~ack & ~req_done;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .eligible    (eligible),
    .rr_last     (rr_last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Unsigned wrap makes addresses below base fail the window test too.
  assign in_range = (sel_addr - base) < limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    case (state)
      S_IDLE: if (enable) state_next = S_RUN;
      S_RUN: begin
        if (!enable) begin
          state_next = S_IDLE;
        end else begin
          grant = grant_valid;
          if (&req_done && !grant_valid) state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack                 <= '0;
      vga_sram_address    <= '0;
      vga_sram_writedata  <= '0;
      vga_sram_write      <= 1'b0;
      vga_sram_clken      <= 1'b0;
      vga_sram_chipselect <= 1'b0;
      range_err           <= 1'b0;
      all_done            <= 1'b0;
      rr_last             <= IDX_W'(N_REQ - 1);
    end else begin
      ack                 <= '0;
      vga_sram_write      <= 1'b0;
      vga_sram_clken      <= 1'b1;
      vga_sram_chipselect <= 1'b1;
      all_done            <= (state_next == S_DONE);
      if (grant) begin
        ack[grant_idx]     <= 1'b1;
        vga_sram_address   <= sel_addr;
        vga_sram_writedata <= sel_data;
        vga_sram_write     <= in_range;
        rr_last            <= grant_idx;
        if (!in_range) range_err <= 1'b1;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [N_REQ-1:0][31:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant && in_range && grant_idx == IDX_W'(i)) count[i] <= count[i] + 32'd1;
      end
    end
  end

  assign write_count = count;
`else
  assign write_count = '0;
`endif

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Shares the single VGA pixel-SRAM write port among N_REQ pixel-producing blocks; each is an iterator plus colour stage working on its own screen slice.
- Arbitration is round-robin, with one registered SRAM write per cycle and a one-cycle ack pulse back to the winner.
- Writes whose address falls outside the configured frame window are dropped.
- Asserts a sticky all_done once every requester reports done and no write is in flight; the HPS polls this flag.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ADDR_W, 32, SRAM address width.
- DATA_W, 8, pixel width (RGB 3-3-2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  grants are issued only while high.
- base  in  ADDR_W  first legal frame address.
- limit  in  ADDR_W  number of legal addresses starting at base.
- req  in  N_REQ  per-requester write request, level.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at slice i.
- req_data  in  N_REQ*DATA_W  packed pixel data.
- req_done  in  N_REQ  requester has finished its slice (sticky at the source).
- ack  out  N_REQ  one-hot, one-cycle pulse: request consumed.
- vga_sram_address  out  ADDR_W  registered write address.
- vga_sram_writedata  out  DATA_W  registered write data.
- vga_sram_write  out  1  write strobe, one cycle per accepted in-range write.
- vga_sram_clken  out  1  SRAM clock enable.
- vga_sram_chipselect  out  1  SRAM chip select.
- range_err  out  1  sticky: at least one write was dropped.
- all_done  out  1  sticky completion flag.
- write_count  out  N_REQ*32  per-requester accepted-write counters (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; state=S_IDLE; round-robin pointer rr_last=N_REQ-1.
  - Reset mid-write aborts the write: vga_sram_write drops to 0 asynchronously, no ack is issued, and requesters must re-present.
- vga_sram_clken and vga_sram_chipselect are registered; both are 1 from the first clk edge after rst deasserts.
- Requester contract:
  - Hold req, req_addr and req_data stable until the ack pulse.
  - On the edge that ends the ack cycle, either deassert req or present the next pixel.
- Eligibility in cycle t: eligible = req & ~ack. The current ack is masked, so a stale request is never granted twice.
- Grant: the first eligible index scanning rr_last+1, rr_last+2, ... modulo N_REQ. A grant is issued only if state==S_RUN and enable==1.
- Latency: grant decided in cycle t; in cycle t+1 ack[g]=1 and the address/data registers hold the granted values.
  - vga_sram_write=1 in t+1 only if (req_addr[g]-base) < limit, computed as an unsigned ADDR_W subtraction, so addresses below base wrap and fail.
  - Otherwise the write stays 0, ack[g] still pulses, and range_err is set.
- rr_last <= g on every grant.
- Throughput:
  - One write per cycle across different requesters.
  - At most one write every 2 cycles for the same requester.
- limit=0: every request is dropped and acked, and range_err is set.
- FSM:
  - S_IDLE -> S_RUN when enable=1.
  - S_RUN -> S_IDLE when enable=0; any grant already issued completes normally.
  - S_RUN -> S_DONE when &req_done==1 and no grant is issued this cycle. req is ignored once its req_done is set.
  - S_DONE: all_done=1 and no grants; leaves only on rst.
- Simultaneous final write and last req_done: the write completes first, and S_DONE is entered the following cycle.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined: write_count slice i is a 32-bit counter incremented on each accepted in-range write by requester i. It wraps at 2^32 and resets to 0.
- When undefined: write_count is tied to 0, no counter logic is built, and the port list is unchanged.

Decomposition:
- Package vga_arb_pkg:
  - arb_state_t enum (S_IDLE, S_RUN, S_DONE).
  - Localparams COLOR_W=8 and DEFAULT_N_REQ=4.
- Sub-module rr_picker: combinational round-robin priority picker.
  - Inputs: eligible[N_REQ], rr_last.
  - Outputs: grant_valid, grant_idx.
- The arbiter instantiates rr_picker once.

Test Plan:
- Single requester: base=0, limit=640*480, req[0] with addr 5, data 0x64 -> ack[0] and write=1 one cycle later; address=5, writedata=0x64.
- All four requesters hold req continuously -> grants in order 0,1,2,3,0,... with one write per cycle; no index repeats within 4 grants.
- Out of range: base=100, limit=10, addr=99 then addr=110 -> both acked, write stays 0, range_err=1; addr=109 -> written.
- Completion: req_done asserted 0..3 staggered while req[3] is still writing -> all_done rises the cycle after the last accepted write and stays high.
- Reset mid-operation: rst asserted during a write cycle -> write, ack and all_done are 0 immediately; after release, clken=chipselect=1 on the next edge and arbitration restarts at index 0.
- With ARB_STATS_EN: 3 in-range writes plus 1 out-of-range write from requester 2 -> write_count slice 2 = 3.
